// File: rtl/opnd_stage_arb_if.sv
// Handshake and payload bundle between the two requesters, the operand stage arbiter
// and the downstream consumer.
`timescale 1ns/1ps
interface opnd_stage_arb_if #(
   parameter int NBYTES = 32,
   parameter int DW     = 32
);
   logic                   req0_valid;
   logic                   req0_ready;
   logic [NBYTES-1:0][7:0] req0_d;
   logic [DW-1:0]          req0_a;
   logic [DW-1:0]          req0_b;

   logic                   req1_valid;
   logic                   req1_ready;
   logic [NBYTES-1:0][7:0] req1_d;
   logic [DW-1:0]          req1_a;
   logic [DW-1:0]          req1_b;

   logic                   out_valid;
   logic                   out_ready;
   logic [NBYTES-1:0][7:0] out_d;
   logic [DW-1:0]          out_a;
   logic [DW-1:0]          out_b;
   logic                   out_src;

   // master: requesters plus downstream consumer; slave: the arbiter itself
   modport master (
      output req0_valid, req0_d, req0_a, req0_b,
      output req1_valid, req1_d, req1_a, req1_b,
      output out_ready,
      input  req0_ready, req1_ready,
      input  out_valid, out_d, out_a, out_b, out_src
   );

   modport slave (
      input  req0_valid, req0_d, req0_a, req0_b,
      input  req1_valid, req1_d, req1_a, req1_b,
      input  out_ready,
      output req0_ready, req1_ready,
      output out_valid, out_d, out_a, out_b, out_src
   );
endinterface

// File: rtl/opnd_stage_arb.sv
// Two-requester round-robin arbiter feeding a single registered operand output stage.
// Optional saturating per-requester accept counters with OPARB_GRANT_CNT_EN.
`timescale 1ns/1ps
module opnd_stage_arb #(
   parameter int NBYTES = 32,
   parameter int DW     = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   opnd_stage_arb_if.slave      bus
`ifdef OPARB_GRANT_CNT_EN
   ,
   output logic [15:0]          gnt_cnt0,
   output logic [15:0]          gnt_cnt1
`endif
);

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic                   last_q;
   logic                   src_q;
   logic [NBYTES-1:0][7:0] out_d_q;
   logic [DW-1:0]          out_a_q;
   logic [DW-1:0]          out_b_q;

   logic gnt;
   logic can_load;
   logic rdy0;
   logic rdy1;
   logic accept;

   // Readies are gated by rst so nothing is offered while reset is held.
   always_comb begin
      gnt      = 1'b0;
      can_load = 1'b0;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      accept   = 1'b0;
      state_d  = state_q;

      if (bus.req0_valid && bus.req1_valid) begin
         gnt = ~last_q;
      end else if (bus.req1_valid) begin
         gnt = 1'b1;
      end

      can_load = (state_q == EMPTY) || bus.out_ready;
      rdy0     = rst & can_load & ~gnt & bus.req0_valid;
      rdy1     = rst & can_load &  gnt & bus.req1_valid;
      accept   = rdy0 | rdy1;

      if (accept) begin
         state_d = FULL;
      end else if ((state_q == FULL) && bus.out_ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Payload only moves on accept; a pop alone leaves the old values in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_d_q <= '0;
         out_a_q <= '0;
         out_b_q <= '0;
         src_q   <= 1'b0;
         last_q  <= 1'b1;
      end else if (accept) begin
         out_d_q <= gnt ? bus.req1_d : bus.req0_d;
         out_a_q <= gnt ? bus.req1_a : bus.req0_a;
         out_b_q <= gnt ? bus.req1_b : bus.req0_b;
         src_q   <= gnt;
         last_q  <= gnt;
      end
   end

`ifdef OPARB_GRANT_CNT_EN
   logic [15:0] cnt0_q;
   logic [15:0] cnt1_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt0_q <= 16'd0;
         cnt1_q <= 16'd0;
      end else begin
         if (rdy0 && (cnt0_q != 16'hFFFF)) begin
            cnt0_q <= cnt0_q + 16'd1;
         end
         if (rdy1 && (cnt1_q != 16'hFFFF)) begin
            cnt1_q <= cnt1_q + 16'd1;
         end
      end
   end

   assign gnt_cnt0 = cnt0_q;
   assign gnt_cnt1 = cnt1_q;
`endif

   assign bus.req0_ready = rdy0;
   assign bus.req1_ready = rdy1;
   assign bus.out_valid  = (state_q == FULL);
   assign bus.out_d      = out_d_q;
   assign bus.out_a      = out_a_q;
   assign bus.out_b      = out_b_q;
   assign bus.out_src    = src_q;

endmodule

// File: tb/tb_opnd_stage_arb.sv
// Scoreboard bench for opnd_stage_arb: accepted bundles are queued, the held output
// is compared against the queue head every cycle it is valid.
`timescale 1ns/1ps
module tb_opnd_stage_arb;
   localparam int NBYTES = 32;
   localparam int DW     = 32;

   typedef struct {
      logic                   src;
      logic [NBYTES*8-1:0]    d;
      logic [DW-1:0]          a;
      logic [DW-1:0]          b;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   int   acc0;
   int   acc1;
   exp_t sb_q[$];

   opnd_stage_arb_if #(.NBYTES(NBYTES), .DW(DW)) bus ();

`ifdef OPARB_GRANT_CNT_EN
   logic [15:0] gnt_cnt0;
   logic [15:0] gnt_cnt1;
   opnd_stage_arb #(.NBYTES(NBYTES), .DW(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .gnt_cnt0 (gnt_cnt0),
      .gnt_cnt1 (gnt_cnt1)
   );
`else
   opnd_stage_arb #(.NBYTES(NBYTES), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [NBYTES*8-1:0] mk_d(input logic [7:0] base);
      logic [NBYTES*8-1:0] v;
      for (int i = 0; i < NBYTES; i++) begin
         v[i*8 +: 8] = base + 8'(i);
      end
      return v;
   endfunction

   task automatic set_req(input int n, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [7:0] base);
      if (n == 0) begin
         bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_d = mk_d(base);
      end else begin
         bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_d = mk_d(base);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_chk();
      check_eq("rst_out_valid", bus.out_valid, 0);
      check_eq("rst_out_a", bus.out_a, 0);
      check_eq("rst_out_b", bus.out_b, 0);
      check_eq("rst_out_d", bus.out_d, 0);
      check_eq("rst_out_src", bus.out_src, 0);
      check_eq("rst_req0_ready", bus.req0_ready, 0);
      check_eq("rst_req1_ready", bus.req1_ready, 0);
`ifdef OPARB_GRANT_CNT_EN
      check_eq("rst_gnt_cnt0", gnt_cnt0, 0);
      check_eq("rst_gnt_cnt1", gnt_cnt1, 0);
`endif
   endtask

   // Scoreboard monitor: compare held payload to queue head, pop on consume, push on accept.
   always @(negedge clk) begin
      if (!rst) begin
         sb_q.delete();
         acc0 = 0;
         acc1 = 0;
      end else begin
         if (bus.out_valid) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_underflow", 1, 0);
            end else begin
               check_eq("sb_src", bus.out_src, sb_q[0].src);
               check_eq("sb_d", bus.out_d, sb_q[0].d);
               check_eq("sb_a", bus.out_a, sb_q[0].a);
               check_eq("sb_b", bus.out_b, sb_q[0].b);
               if (bus.out_ready) void'(sb_q.pop_front());
            end
         end
         if (bus.req0_ready && bus.req1_ready) check_eq("one_grant", 1, 0);
         if (bus.req0_valid && bus.req0_ready) begin
            sb_q.push_back('{src: 1'b0, d: bus.req0_d, a: bus.req0_a, b: bus.req0_b});
            acc0++;
         end
         if (bus.req1_valid && bus.req1_ready) begin
            sb_q.push_back('{src: 1'b1, d: bus.req1_d, a: bus.req1_a, b: bus.req1_b});
            acc1++;
         end
      end
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      acc0     = 0;
      acc1     = 0;
      rst      = 1'b0;
      bus.out_ready = 1'b0;
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b0, 0, 0, 0);

      // Reset with random inputs, before and across edges
      #1;
      rst_chk();
      repeat (3) begin
         step();
         set_req(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom));
         set_req(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 8'($urandom));
         bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         rst_chk();
      end
      step();
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b0, 0, 0, 0);
      bus.out_ready = 1'b1;
      rst = 1'b1;

      // Single requester
      step();
      set_req(0, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 8'h00);
      @(negedge clk);
      check_eq("single_rdy0", bus.req0_ready, 1);
      check_eq("single_rdy1", bus.req1_ready, 0);
      step();
      set_req(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("single_valid", bus.out_valid, 1);
      check_eq("single_src", bus.out_src, 0);
      check_eq("single_a", bus.out_a, 32'h1234_5678);
      check_eq("single_b", bus.out_b, 32'hDEAD_BEEF);
      check_eq("single_d", bus.out_d, mk_d(8'h00));

      // Drain: one req1 bundle then no requests; payload must remain after pop
      step();
      set_req(1, 1'b1, 32'h5555_0001, 32'h6666_0001, 8'h40);
      @(negedge clk);
      check_eq("drain_rdy1", bus.req1_ready, 1);
      step();
      set_req(1, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("drain_full", bus.out_valid, 1);
      step();
      @(negedge clk);
      check_eq("drain_empty", bus.out_valid, 0);
      check_eq("drain_keep_a", bus.out_a, 32'h5555_0001);
      check_eq("drain_keep_src", bus.out_src, 1);
      check_eq("drain_keep_d", bus.out_d, mk_d(8'h40));

      // Contention: both valid for 8 cycles, grants alternate starting with req0
      for (int i = 0; i < 8; i++) begin
         step();
         set_req(0, 1'b1, {16'hA000, 16'(i)}, {16'hA100, 16'(i)}, 8'(i));
         set_req(1, 1'b1, {16'hB000, 16'(i)}, {16'hB100, 16'(i)}, 8'(8'h80 + i));
         @(negedge clk);
         check_eq("cont_rdy0", bus.req0_ready, (i % 2) == 0);
         check_eq("cont_rdy1", bus.req1_ready, (i % 2) == 1);
         if (i > 0) check_eq("cont_src", bus.out_src, ((i - 1) % 2) == 1);
      end
      step();
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("cont_last_src", bus.out_src, 1);
`ifdef OPARB_GRANT_CNT_EN
      check_eq("cnt0", gnt_cnt0, 16'(acc0));
      check_eq("cnt1", gnt_cnt1, 16'(acc1));
      check_eq("cnt0_abs", gnt_cnt0, 16'd5);
      check_eq("cnt1_abs", gnt_cnt1, 16'd5);
`endif
      step();

      // Backpressure: req1 loaded, req0 held off while out_ready low
      bus.out_ready = 1'b0;
      set_req(1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 8'hC0);
      @(negedge clk);
      check_eq("bp_rdy1", bus.req1_ready, 1);
      step();
      set_req(1, 1'b0, 0, 0, 0);
      set_req(0, 1'b1, 32'h0C0C_0C0C, 32'hC0C0_C0C0, 8'h10);
      repeat (5) begin
         @(negedge clk);
         check_eq("bp_rdy0_low", bus.req0_ready, 0);
         check_eq("bp_hold_a", bus.out_a, 32'hA5A5_A5A5);
         check_eq("bp_hold_valid", bus.out_valid, 1);
         step();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_rdy0_release", bus.req0_ready, 1);
      step();
      set_req(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("bp_src", bus.out_src, 0);
      check_eq("bp_a", bus.out_a, 32'h0C0C_0C0C);
      step();
      @(negedge clk);
      check_eq("bp_drained", bus.out_valid, 0);

      // Async reset while FULL
      step();
      bus.out_ready = 1'b0;
      set_req(0, 1'b1, 32'h7777_0000, 32'h8888_0000, 8'h20);
      @(negedge clk);
      check_eq("ar_rdy0", bus.req0_ready, 1);
      step();
      set_req(0, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("ar_full", bus.out_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      rst_chk();
      step();
      @(negedge clk);
      rst_chk();
      step();
      set_req(0, 1'b1, 32'h0101_0101, 32'h0202_0202, 8'h50);
      set_req(1, 1'b1, 32'h0303_0303, 32'h0404_0404, 8'h60);
      bus.out_ready = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      check_eq("ar_tie_rdy0", bus.req0_ready, 1);
      check_eq("ar_tie_rdy1", bus.req1_ready, 0);
      step();
      set_req(0, 1'b0, 0, 0, 0);
      set_req(1, 1'b0, 0, 0, 0);
      @(negedge clk);
      check_eq("ar_tie_src", bus.out_src, 0);
      check_eq("ar_tie_a", bus.out_a, 32'h0101_0101);
      step();
      step();
      @(negedge clk);
      check_eq("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
